// File: rtl/sobel_pixel_tx_if.sv
`default_nettype none
// sobel_pixel_tx_if -- host word input and pixel output bundle of sobel_pixel_tx (rev 1.0).
interface sobel_pixel_tx_if #(
  parameter int IN_W = 64
) ();
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_last;
  logic [7:0]      out_slot;
  logic [7:0]      out_pad;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid, out_last, out_slot, out_pad
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid, out_last, out_slot, out_pad
  );
endinterface
`default_nettype wire

// File: rtl/sobel_pixel_tx.sv
`default_nettype none
// sobel_pixel_tx -- serializes host words LSB-byte-first into one frame of 8-bit pixels (rev 1.0).
// Define SOBEL_TX_FLUSH_EN to append IMG_WIDTH+2 zero drain pixels after each image.
module sobel_pixel_tx #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int IN_W       = 64,
  parameter int SLOT_ID    = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       start,
  input  wire logic       pause,
  output logic            busy,
  output logic            frame_done,
  sobel_pixel_tx_if.slave bus
);

  localparam int NB = IN_W / 8;
  localparam int BW = $clog2(NB);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [BW-1:0] c_BYTE_LAST = BW'(NB - 1);
  localparam logic [CW-1:0] c_COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] c_ROW_LAST  = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [IN_W-1:0] r_word;
  logic            r_word_valid;
  logic [BW-1:0]   r_byte_idx;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_out_data;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_busy;
  logic            r_frame_done;

`ifdef SOBEL_TX_FLUSH_EN
  localparam int FW = $clog2(IMG_WIDTH + 2);
  localparam logic [FW-1:0] c_FLUSH_LAST = FW'(IMG_WIDTH + 1);
  logic [FW-1:0] r_flush_cnt;
`endif

  logic       w_emit;
  logic       w_last_byte;
  logic       w_final_pix;
  logic       w_in_ready;
  logic       w_accept;
  logic [7:0] w_byte;

  assign w_emit      = (r_state == ST_STREAM) && r_word_valid && !pause;
  assign w_last_byte = (r_byte_idx == c_BYTE_LAST);
  assign w_final_pix = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
  // Refill in the same cycle the last byte leaves, so words stream without a bubble.
  assign w_in_ready  = (r_state == ST_STREAM) && (!r_word_valid || (w_emit && w_last_byte));
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_byte      = r_word[{r_byte_idx, 3'b000} +: 8];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_slot  = 8'(SLOT_ID);
  assign bus.out_pad   = 8'd0;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_byte_idx   <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_out_data   <= 8'd0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef SOBEL_TX_FLUSH_EN
      r_flush_cnt  <= '0;
`endif
    end else begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_STREAM;
            r_busy       <= 1'b1;
            r_col        <= '0;
            r_row        <= '0;
            r_byte_idx   <= '0;
            r_word_valid <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (w_accept) begin
            r_word       <= bus.in_data;
            r_word_valid <= 1'b1;
          end
          if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_byte;
            r_byte_idx  <= w_last_byte ? '0 : r_byte_idx + 1'b1;
            if (w_last_byte && !w_accept) begin
              r_word_valid <= 1'b0;
            end
            // The frame ends here; any bytes left in the held word are dropped.
            if (w_final_pix) begin
              r_word_valid <= 1'b0;
              r_byte_idx   <= '0;
`ifdef SOBEL_TX_FLUSH_EN
              r_flush_cnt  <= '0;
              r_state      <= ST_FLUSH;
`else
              r_out_last   <= 1'b1;
              r_state      <= ST_DONE;
`endif
            end else if (r_col == c_COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
`ifdef SOBEL_TX_FLUSH_EN
        ST_FLUSH: begin
          if (!pause) begin
            r_out_valid <= 1'b1;
            r_out_data  <= 8'd0;
            r_flush_cnt <= r_flush_cnt + 1'b1;
            if (r_flush_cnt == c_FLUSH_LAST) begin
              r_out_last <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
        end
`endif
        ST_DONE: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
